// File: rtl/ram_arb_sx.sv
// ram_arb_sx: round-robin arbiter sharing one single-port synchronous RAM
// between NReq requesters. Grants are combinational (same cycle as the RAM
// drive). Read data is routed back to its issuer with a registered one-hot
// valid strobe that lines up with the RAM's one-cycle read latency.
module ram_arb_sx #(
  parameter int NReq     = 4,
  parameter int CAddrLen = 13,
  parameter int CDataLen = 128
) (
  input  logic                     AClkH,
  input  logic                     AResetH,
  input  logic                     AClkHEn,
  input  logic [NReq*CAddrLen-1:0] AReqAddr,
  input  logic [NReq*CDataLen-1:0] AReqMosi,
  input  logic [NReq-1:0]          AReqWrEn,
  input  logic [NReq-1:0]          AReqRdEn,
  output logic [NReq-1:0]          AReqAck,
  output logic [CDataLen-1:0]      AReqMiso,
  output logic [NReq-1:0]          AReqMisoVld,
  output logic [CAddrLen-1:0]      ARamAddr,
  output logic [CDataLen-1:0]      ARamMosi,
  output logic                     ARamWrEn,
  output logic                     ARamRdEn,
  input  logic [CDataLen-1:0]      ARamMiso
);

  localparam int PW = $clog2(NReq);

  // Priority pointer: index searched first on the next enabled cycle.
  logic [PW-1:0]   r_ptr;
  // One-hot owner of the read issued on the previous enabled cycle.
  logic [NReq-1:0] r_rd_tag;

  logic [NReq-1:0] w_req;
  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_sel;
  logic [PW-1:0]   w_ptr_nxt;
  logic            w_grant;

  assign w_req = AReqWrEn | AReqRdEn;

  // Rotating search: first requesting index at or after r_ptr, modulo NReq.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned (which would infer a latch); blocking '='
    // is correct here because later loop iterations read earlier results.
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < NReq; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NReq);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Only an enabled, out-of-reset cycle may grant anything.
  assign w_grant = w_found & AClkHEn & ~AResetH;

  // Address/data mux follows the winner, or the pointer slice when idle
  // (value is don't-care then; the strobes are low).
  assign w_sel = w_found ? w_win : r_ptr;

  // Select the RAM address and write data from the chosen requester slice.
  always_comb begin
    ARamAddr = AReqAddr[CAddrLen-1:0];
    ARamMosi = AReqMosi[CDataLen-1:0];
    for (int i = 0; i < NReq; i++) begin
      if (w_sel == PW'(i)) begin
        ARamAddr = AReqAddr[i*CAddrLen +: CAddrLen];
        ARamMosi = AReqMosi[i*CDataLen +: CDataLen];
      end
    end
  end

  // A request with both strobes set is a write only.
  assign ARamWrEn = w_grant & AReqWrEn[w_win];
  assign ARamRdEn = w_grant & AReqRdEn[w_win] & ~AReqWrEn[w_win];

  // One-hot acknowledge to the winner.
  always_comb begin
    AReqAck = '0;
    for (int i = 0; i < NReq; i++) begin
      AReqAck[i] = w_grant && (w_win == PW'(i));
    end
  end

  assign w_ptr_nxt = (w_win == PW'(NReq - 1)) ? '0 : w_win + PW'(1);

  // Pointer advance and read-tag capture; both hold while the enable is low.
  always_ff @(posedge AClkH) begin
    // NOTE: registered state uses non-blocking '<=' so every flop samples
    // pre-edge values, independent of statement order.
    if (AResetH) begin
      r_ptr    <= '0;
      r_rd_tag <= '0;
    end else if (AClkHEn) begin
      if (w_grant) begin
        r_ptr <= w_ptr_nxt;
      end
      r_rd_tag <= ARamRdEn ? AReqAck : '0;
    end
  end

  assign AReqMisoVld = r_rd_tag;
  // RAM output is already gated by its own registered read enable.
  assign AReqMiso    = ARamMiso;

endmodule
